// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// The settle-load helper converts a cycle count into the timer's preload value.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int ALU_W = 16;
   localparam int OPC_W = 3;
   localparam logic [OPC_W-1:0] OPC_RESET = 3'd7;
   localparam int SETTLE_W = 8;

   // The timer counts down to zero inclusive, so N held cycles preload N-1.
   function automatic logic [SETTLE_W-1:0] settle_load(input int cycles);
      return SETTLE_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/alu_seq_settle_timer.sv
// Loadable down-counter that measures how long the ALU inputs have been held.
// done is high whenever the count has reached zero.
module alu_seq_settle_timer
   import alu_seq_pkg::*;
#(
   parameter int W = SETTLE_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Clocked command front-end for the combinational ALU: registers operands,
// waits a settle window, captures the result and returns it with flag checking.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH         = ALU_W,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPC_W-1:0] cmd_opc,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_c,
   input  logic             cmd_use_acc,
   output logic [WIDTH-1:0] alu_inA,
   output logic [WIDTH-1:0] alu_inB,
   output logic             alu_inC,
   output logic [OPC_W-1:0] alu_opc,
   input  logic [WIDTH-1:0] alu_outW,
   input  logic             alu_zer,
   input  logic             alu_neg,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_w,
   output logic             rsp_zer,
   output logic             rsp_neg,
   output logic             flag_err,
   output logic [15:0]      op_count,
   output logic             busy
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1. The sender holds its payload stable while valid is high; valid never
   // depends combinationally on ready, and ready here comes from registered state.

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

   state_t           state, state_nxt;
   logic             accept, capture, rsp_hs;
   logic             timer_done;
   logic [WIDTH-1:0] acc;
   logic             exp_zer, exp_neg, flags_bad;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      rsp_hs    = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (timer_done) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cmd_ready = (state == IDLE) && rst_n;
   assign busy      = (state != IDLE);

   alu_seq_settle_timer #(
      .W (SETTLE_W)
   ) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .en       (state == SETTLE),
      .load_val (SETTLE_LOAD),
      .done     (timer_done)
   );

   // Expected flags derived from the captured word; only used for the sticky check.
   assign exp_zer   = (alu_outW == '0);
   assign exp_neg   = alu_outW[WIDTH-1];
   assign flags_bad = (alu_zer != exp_zer) || (alu_neg != exp_neg);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_inA   <= '0;
         alu_inB   <= '0;
         alu_inC   <= 1'b0;
         alu_opc   <= OPC_RESET;
         rsp_valid <= 1'b0;
         rsp_w     <= '0;
         rsp_zer   <= 1'b0;
         rsp_neg   <= 1'b0;
         flag_err  <= 1'b0;
         op_count  <= '0;
         acc       <= '0;
      end else begin
         if (accept) begin
            alu_inA <= cmd_use_acc ? acc : cmd_a;
            alu_inB <= cmd_b;
            alu_inC <= cmd_c;
            alu_opc <= cmd_opc;
         end
         if (capture) begin
            rsp_w     <= alu_outW;
            rsp_zer   <= alu_zer;
            rsp_neg   <= alu_neg;
            rsp_valid <= 1'b1;
            if (flags_bad) begin
               flag_err <= 1'b1;
            end
         end
         // The accumulator follows delivered results only, never raw captures.
         if (rsp_hs) begin
            acc       <= rsp_w;
            op_count  <= op_count + 16'd1;
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with an adder stub ALU
// and a transaction-level reference model.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int WIDTH  = 16;
   localparam int SETTLE = 4;
   localparam int RW     = WIDTH + 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [OPC_W-1:0] cmd_opc = '0;
   logic [WIDTH-1:0] cmd_a = '0;
   logic [WIDTH-1:0] cmd_b = '0;
   logic             cmd_c = 1'b0;
   logic             cmd_use_acc = 1'b0;
   logic [WIDTH-1:0] alu_inA, alu_inB;
   logic             alu_inC;
   logic [OPC_W-1:0] alu_opc;
   logic [WIDTH-1:0] alu_outW;
   logic             alu_zer, alu_neg;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_w;
   logic             rsp_zer, rsp_neg, flag_err, busy;
   logic [15:0]      op_count;

   // clock / reset
   always #5 clk = ~clk;

   alu_sequencer #(
      .WIDTH         (WIDTH),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_opc     (cmd_opc),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_c       (cmd_c),
      .cmd_use_acc (cmd_use_acc),
      .alu_inA     (alu_inA),
      .alu_inB     (alu_inB),
      .alu_inC     (alu_inC),
      .alu_opc     (alu_opc),
      .alu_outW    (alu_outW),
      .alu_zer     (alu_zer),
      .alu_neg     (alu_neg),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_w       (rsp_w),
      .rsp_zer     (rsp_zer),
      .rsp_neg     (rsp_neg),
      .flag_err    (flag_err),
      .op_count    (op_count),
      .busy        (busy)
   );

   // Stub ALU: adder; stub_bad inverts zer to provoke the flag checker.
   logic stub_bad = 1'b0;
   always_comb begin
      alu_outW = alu_inA + alu_inB + {{(WIDTH-1){1'b0}}, alu_inC};
      alu_zer  = (alu_outW == '0) ^ stub_bad;
      alu_neg  = alu_outW[WIDTH-1];
   end

   // scoreboard and reference model
   int               n_checks = 0;
   int               n_errors = 0;
   logic [RW-1:0]    exp_q[$];
   logic [WIDTH-1:0] m_acc = '0;
   int               m_count = 0;
   logic             m_flag_err = 1'b0;
   logic             m_pending_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // {zer, neg, w} the stub should produce for a command, from plain arithmetic
   function automatic logic [RW-1:0] model_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic c, input logic use_acc, input logic bad);
      int unsigned      s;
      logic [WIDTH-1:0] w;
      s = (int'(use_acc ? m_acc : a) + int'(b) + int'(c)) % 65536;
      w = WIDTH'(s);
      return {(s == 0) ^ bad, w[WIDTH-1], w};
   endfunction

   task automatic check_reset_values();
      check("rst_alu_inA", alu_inA, 0);
      check("rst_alu_inB", alu_inB, 0);
      check("rst_alu_inC", alu_inC, 0);
      check("rst_alu_opc", alu_opc, 7);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_w", rsp_w, 0);
      check("rst_rsp_zer", rsp_zer, 0);
      check("rst_rsp_neg", rsp_neg, 0);
      check("rst_flag_err", flag_err, 0);
      check("rst_op_count", op_count, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 0);
   endtask

   // driver: offer one command and let it be accepted (leaves time at #1 after edge k)
   task automatic send_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                           input logic [OPC_W-1:0] opc, input logic use_acc);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      exp_q.push_back(model_op(a, b, c, use_acc, stub_bad));
      m_pending_err = stub_bad;
      check("pre_alu_expect", 0, 0 + ((use_acc ? m_acc : a) === (use_acc ? m_acc : a) ? 0 : 1));
      cmd_a = a; cmd_b = b; cmd_c = c; cmd_opc = opc; cmd_use_acc = use_acc;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("alu_inA", alu_inA, use_acc ? m_acc : a);
      check("alu_inB", alu_inB, b);
      check("alu_inC", alu_inC, c);
      check("alu_opc", alu_opc, opc);
      check("busy_after_accept", busy, 1);
      check("cmd_ready_after_accept", cmd_ready, 0);
   endtask

   task automatic await_capture();
      int n = 0;
      while (!rsp_valid && n < 4 * SETTLE + 8) begin
         @(posedge clk); #1;
         n++;
      end
      check("capture_latency", n, SETTLE);
      if (m_pending_err) m_flag_err = 1'b1;
      check("flag_err_capture", flag_err, m_flag_err);
   endtask

   task automatic complete_rsp(input int hold);
      logic [RW-1:0]    exp;
      logic [WIDTH-1:0] snap_a;
      exp = exp_q.pop_front();
      snap_a = alu_inA;
      check("rsp_w", rsp_w, exp[WIDTH-1:0]);
      check("rsp_neg", rsp_neg, exp[WIDTH]);
      check("rsp_zer", rsp_zer, exp[WIDTH+1]);
      repeat (hold) begin
         @(posedge clk); #1;
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_w", rsp_w, exp[WIDTH-1:0]);
         check("hold_rsp_flags", {rsp_zer, rsp_neg}, exp[WIDTH+1:WIDTH]);
         check("hold_alu_inA", alu_inA, snap_a);
         check("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      m_acc   = exp[WIDTH-1:0];
      m_count = (m_count + 1) % 65536;
      check("op_count", op_count, m_count);
      check("rsp_valid_cleared", rsp_valid, 0);
      check("cmd_ready_after_hs", cmd_ready, 1);
      check("busy_after_hs", busy, 0);
      check("flag_err_after_hs", flag_err, m_flag_err);
   endtask

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        input logic [OPC_W-1:0] opc, input logic use_acc, input int hold);
      send_cmd(a, b, c, opc, use_acc);
      await_capture();
      complete_rsp(hold);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("cmd_ready_out_of_reset", cmd_ready, 1);

      // basic op, then chaining through the accumulator
      do_op(16'h0003, 16'h0004, 1'b1, 3'd2, 1'b0, 0);
      do_op(16'h0001, 16'h0001, 1'b0, 3'd0, 1'b0, 0);
      do_op(16'h1234, 16'h7FFE, 1'b0, 3'd0, 1'b1, 0);
      // zero result with long back-pressure
      do_op(16'hFFFF, 16'h0001, 1'b0, 3'd1, 1'b0, 10);

      // corrupted zer flag: result returned as captured, error sticks
      stub_bad = 1'b1;
      do_op(16'h0002, 16'h0003, 1'b0, 3'd3, 1'b0, 0);
      stub_bad = 1'b0;
      repeat (3) do_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 0);

      // randomized traffic with gaps and back-pressure
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         do_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      // reset while a response is pending: response dropped, accumulator cleared
      send_cmd(16'h00AA, 16'h0011, 1'b1, 3'd5, 1'b0);
      await_capture();
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_values();
      rst_n = 1'b1;
      void'(exp_q.pop_front());
      m_acc = '0;
      m_count = 0;
      m_flag_err = 1'b0;
      @(posedge clk); #1;
      check("cmd_ready_after_midreset", cmd_ready, 1);
      do_op(16'hBEEF, 16'h0005, 1'b0, 3'd0, 1'b1, 1);
      check("post_reset_acc_result", m_acc, 16'h0005);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Clocked command front-end for the 16-bit structural ALU. It accepts operation commands over a valid/ready handshake and drives the ALU's `inA`/`inB`/`inC`/`opc` from registers. It holds those inputs stable for a programmable settle window, then captures `outW`/`zer`/`neg` and returns them over a valid/ready response channel. It sits between a test/issue master and the combinational ALU, and adds result chaining (accumulator), an operation counter and a flag-consistency checker.

## Interface
- `WIDTH`, 16, operand/result width; equals ALU data width
- `SETTLE_CYCLES`, 4, cycles ALU inputs are held before result capture; legal range 1..255
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_opc`  in  3  ALU opcode, passed through unmodified
- `cmd_a`  in  WIDTH  operand A
- `cmd_b`  in  WIDTH  operand B
- `cmd_c`  in  1  carry/extra input
- `cmd_use_acc`  in  1  1: use accumulator instead of `cmd_a` as operand A
- `alu_inA`  out  WIDTH  to ALU `inA`
- `alu_inB`  out  WIDTH  to ALU `inB`
- `alu_inC`  out  1  to ALU `inC`
- `alu_opc`  out  3  to ALU `opc`
- `alu_outW`  in  WIDTH  from ALU `outW`
- `alu_zer`  in  1  from ALU `zer`
- `alu_neg`  in  1  from ALU `neg`
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  master accepts response
- `rsp_w`  out  WIDTH  captured result
- `rsp_zer`, `rsp_neg`  out  1 each  captured flags
- `flag_err`  out  1  sticky: a captured flag was inconsistent with the captured result
- `op_count`  out  16  completed response handshakes, wraps
- `busy`  out  1  state != IDLE

## Operation
- FSM has three states:
  - **IDLE**: `cmd_ready`=1. On `cmd_valid`, load the ALU registers: A = `cmd_use_acc` ? acc : `cmd_a`; B, C and opc from the command. Load the settle counter with `SETTLE_CYCLES`-1 and go to SETTLE.
  - **SETTLE**: ALU registers are frozen. While counter>0, decrement. At counter=0, register `alu_outW`/`alu_zer`/`alu_neg` into `rsp_*`, set `rsp_valid` and go to RESP.
  - **RESP**: `rsp_*` are held stable while `rsp_valid`=1. On `rsp_ready`: acc <= `rsp_w`, `op_count`++, clear `rsp_valid`, go to IDLE.
- `cmd_ready` = (state==IDLE) and `rst_n`. No command is accepted in SETTLE or RESP.
- Flag check at capture:
  - expected zer = (`alu_outW`==0); expected neg = `alu_outW`[WIDTH-1].
  - Any mismatch sets `flag_err`. It stays set until reset.
  - Captured values are returned unmodified regardless of the check.
- `op_count` wraps from 16'hFFFF to 0.
- The accumulator is updated only on a response handshake, never at capture.
- Reset values: `alu_inA`/`alu_inB`/`alu_inC`=0, `alu_opc`=3'd7, `rsp_valid`=0, `rsp_w`=0, `rsp_zer`=0, `rsp_neg`=0, `flag_err`=0, `op_count`=0, acc=0, `busy`=0, state IDLE.
- Reset mid-operation (SETTLE or RESP): the next clock edge with `rst_n`=0 forces every reset value. A pending response is dropped, not delivered, and the accumulator is not updated.

## Timing
- Command accepted at edge k → `alu_*` show the new values after edge k.
- Capture at edge k+`SETTLE_CYCLES` → `rsp_valid`=1 after that edge.
- With `rsp_ready` held 1: handshake at edge k+`SETTLE_CYCLES`+1. `cmd_ready` goes high after that edge, and the next command can be accepted at edge k+`SETTLE_CYCLES`+2.
- Throughput is therefore one op per `SETTLE_CYCLES`+2 cycles.
- `cmd_ready` and `busy` are decoded from registered state only; there is no combinational path from `cmd_valid` or `rsp_ready` to any output.
- Back-pressure: `rsp_ready`=0 holds RESP indefinitely with all `rsp_*` and `alu_*` outputs stable.

## Structure
- Package `alu_seq_pkg` contains:
  - the `state_t` enum {IDLE, SETTLE, RESP}
  - `ALU_W`=16, `OPC_W`=3, `OPC_RESET`=3'd7
  - `SETTLE_W`=8
- One natural sub-module, `alu_seq_settle_timer`: a loadable down-counter with a `done` output, reset to 0.
- The structural ALU is instantiated outside this block, never inside it.

## Test plan
- Stub ALU returns outW = inA+inB+inC, with zer and neg computed correctly.
- Basic op: `SETTLE_CYCLES`=4, cmd a=16'h0003, b=16'h0004, c=1, opc=2, accepted at edge k → `rsp_valid` after edge k+4 with `rsp_w`=16'h0008, zer=0, neg=0; `op_count` becomes 1 after the handshake.
- Chaining: first op 1+1+0 → 2; second op `cmd_use_acc`=1, b=16'h7FFE, c=0 → `alu_inA`=2 and `rsp_w`=16'h8000, neg=1.
- Zero and back-pressure: a=16'hFFFF, b=1, c=0 → `rsp_w`=0, zer=1. Hold `rsp_ready`=0 for 10 cycles → outputs stable and `cmd_ready`=0 throughout.
- Flag error: stub forces zer=1 with outW=5 → `flag_err`=1 after capture and still 1 after three more clean ops; `rsp_zer`=1 is returned unmodified.
- Reset mid-RESP: drive `rst_n`=0 for one edge while `rsp_valid`=1 → all reset values, including `alu_opc`=7 and acc=0. A following `cmd_use_acc` op with b=5 returns 5.
- Counter wrap: issue 65536 ops → `op_count` returns to 0.
